// File: rtl/posit_encode_round.sv
// Posit encode stage: packs sign/regime/exponent/mantissa into an N-bit posit.
// Two-stage valid/ready pipeline with round-to-nearest-even and maxpos/minpos saturation.
module posit_encode_round #(
  parameter int unsigned N  = 8,
  parameter int unsigned S  = $clog2(N),
  parameter int unsigned ES = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              in_is_zero,
  input  logic                              in_is_inf,
  input  logic                              in_sign,
  input  logic [N-1:0]                      in_k,
  input  logic [((ES > 0) ? ES : 1)-1:0]    in_exp,
  input  logic [N-1:0]                      in_mant,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [N-1:0]                      out_posit
);

  localparam int unsigned L    = 2 * N + ES;
  localparam int unsigned BW   = N - 1;
  localparam int unsigned RW   = S + 1;
  localparam int          KMAX = int'(N) - 2;

  logic          s2_adv, s1_adv;

  logic          s1_valid_q, s1_valid_d;
  logic [BW-1:0] s1_body_q, s1_body_d;
  logic          s1_guard_q, s1_guard_d;
  logic          s1_sticky_q, s1_sticky_d;
  logic          s1_sign_q, s1_sign_d;
  logic          s1_inf_q, s1_inf_d;
  logic          s1_zero_q, s1_zero_d;
  logic          s1_sat_hi_q, s1_sat_hi_d;
  logic          s1_sat_lo_q, s1_sat_lo_d;

  logic          s2_valid_q, s2_valid_d;
  logic [N-1:0]  out_posit_q, out_posit_d;

  int            k_c;
  logic          sat_hi, sat_lo;
  logic [RW-1:0] rlen;
  logic [L-1:0]  regime, tail, bit_str;

  logic          round_up;
  logic [BW-1:0] rbody, mag;
  logic [N-1:0]  packed_pos, packed_val;

  always_comb begin
    s2_adv = !s2_valid_q || out_ready;
    s1_adv = !s1_valid_q || s2_adv;
  end

  assign in_ready  = s1_adv;
  assign out_valid = s2_valid_q;
  assign out_posit = out_posit_q;

  // Stage 1: clamp k, lay out regime|exp|fraction left-aligned, split body/guard/sticky.
  always_comb begin
    k_c    = 32'($signed(in_k));
    sat_hi = k_c > KMAX;
    sat_lo = k_c < -KMAX;
    if (sat_hi) begin
      k_c = KMAX;
    end else if (sat_lo) begin
      k_c = -KMAX;
    end
    if (k_c >= 0) begin
      rlen   = RW'(k_c + 2);
      regime = ~({L{1'b1}} >> (k_c + 1));
    end else begin
      rlen   = RW'(1 - k_c);
      regime = {1'b1, {(L-1){1'b0}}} >> (-k_c);
    end
    // Shifting the full mantissa left by one drops the hidden bit.
    tail    = (L'(in_exp) << (L - ES)) | (({in_mant, {(L-N){1'b0}}} << 1) >> ES);
    bit_str = regime | (tail >> rlen);
  end

  // Stage 2: round to nearest even, saturate, apply specials and sign.
  always_comb begin
    round_up = s1_guard_q && (s1_sticky_q || s1_body_q[0]);
    rbody    = s1_body_q + BW'(round_up);
    if (s1_sat_hi_q || (&s1_body_q)) begin
      mag = {BW{1'b1}};
    end else if (s1_sat_lo_q || (rbody == '0)) begin
      mag = BW'(1);
    end else begin
      mag = rbody;
    end
    packed_pos = {1'b0, mag};
    if (s1_inf_q) begin
      packed_val = {1'b1, {(N-1){1'b0}}};
    end else if (s1_zero_q) begin
      packed_val = '0;
    end else if (s1_sign_q) begin
      packed_val = ~packed_pos + N'(1);
    end else begin
      packed_val = packed_pos;
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_body_d   = s1_body_q;
    s1_guard_d  = s1_guard_q;
    s1_sticky_d = s1_sticky_q;
    s1_sign_d   = s1_sign_q;
    s1_inf_d    = s1_inf_q;
    s1_zero_d   = s1_zero_q;
    s1_sat_hi_d = s1_sat_hi_q;
    s1_sat_lo_d = s1_sat_lo_q;
    s2_valid_d  = s2_valid_q;
    out_posit_d = out_posit_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
    end
    if (s1_adv && in_valid) begin
      s1_body_d   = bit_str[L-1 -: BW];
      s1_guard_d  = bit_str[L-N];
      s1_sticky_d = |bit_str[L-N-1:0];
      s1_sign_d   = in_sign;
      s1_inf_d    = in_is_inf;
      s1_zero_d   = in_is_zero;
      s1_sat_hi_d = sat_hi;
      s1_sat_lo_d = sat_lo;
    end
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_posit_d = packed_val;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_body_q   <= '0;
      s1_guard_q  <= 1'b0;
      s1_sticky_q <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_inf_q    <= 1'b0;
      s1_zero_q   <= 1'b0;
      s1_sat_hi_q <= 1'b0;
      s1_sat_lo_q <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_posit_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_body_q   <= s1_body_d;
      s1_guard_q  <= s1_guard_d;
      s1_sticky_q <= s1_sticky_d;
      s1_sign_q   <= s1_sign_d;
      s1_inf_q    <= s1_inf_d;
      s1_zero_q   <= s1_zero_d;
      s1_sat_hi_q <= s1_sat_hi_d;
      s1_sat_lo_q <= s1_sat_lo_d;
      s2_valid_q  <= s2_valid_d;
      out_posit_q <= out_posit_d;
    end
  end

endmodule

// File: tb/tb_posit_encode_round.sv
// Scoreboard bench for posit_encode_round (P8E0): directed plan vectors,
// backpressure, mid-stream reset and randomised traffic with random out_ready.
module tb_posit_encode_round;

  localparam int N  = 8;
  localparam int ES = 0;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         in_is_zero = 1'b0;
  logic         in_is_inf = 1'b0;
  logic         in_sign = 1'b0;
  logic [N-1:0] in_k = '0;
  logic [0:0]   in_exp = '0;
  logic [N-1:0] in_mant = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [N-1:0] out_posit;

  int           n_checks = 0;
  int           n_errors = 0;
  int           n_out = 0;
  logic [N-1:0] sb[$];
  logic         use_model = 1'b0;
  logic         bp_rand = 1'b0;
  logic [N-1:0] cur_exp = '0;

  posit_encode_round #(.N(N), .ES(ES)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_is_zero(in_is_zero), .in_is_inf(in_is_inf), .in_sign(in_sign),
    .in_k(in_k), .in_exp(in_exp), .in_mant(in_mant),
    .out_valid(out_valid), .out_ready(out_ready), .out_posit(out_posit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Bit-serial reference encoder.
  function automatic logic [N-1:0] ref_posit(input logic inf, input logic zero, input logic sgn,
                                             input logic [N-1:0] k, input logic [N-1:0] m);
    bit bits [64];
    int n, ki, body, maxb;
    bit hi, lo, guard, sticky;
    if (inf) return {1'b1, {(N-1){1'b0}}};
    if (zero) return '0;
    ki = int'($signed(k));
    hi = ki > N - 2;
    lo = ki < -(N - 2);
    if (hi) ki = N - 2;
    if (lo) ki = -(N - 2);
    foreach (bits[i]) bits[i] = 1'b0;
    n = 0;
    if (ki >= 0) begin
      for (int i = 0; i <= ki; i++) begin bits[n] = 1'b1; n++; end
      bits[n] = 1'b0; n++;
    end else begin
      for (int i = 0; i < -ki; i++) begin bits[n] = 1'b0; n++; end
      bits[n] = 1'b1; n++;
    end
    for (int i = N - 2; i >= 0; i--) begin bits[n] = m[i]; n++; end
    body = 0;
    for (int i = 0; i < N - 1; i++) body = body * 2 + int'(bits[i]);
    guard = bits[N-1];
    sticky = 1'b0;
    for (int i = N; i < 64; i++) sticky |= bits[i];
    if (guard && (sticky || body[0])) body++;
    maxb = (1 << (N - 1)) - 1;
    if (hi || body >= maxb) body = maxb;
    if (lo || body == 0) body = 1;
    return sgn ? N'(-body) : N'(body);
  endfunction

  // Push on accept, pop and compare on output.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        n_out++;
        if (sb.size() == 0) check("spurious_out", 32'(sb.size()), 1);
        else check("data", out_posit, sb.pop_front());
      end
      if (in_valid && in_ready)
        sb.push_back(use_model ? ref_posit(in_is_inf, in_is_zero, in_sign, in_k, in_mant) : cur_exp);
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (bp_rand) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic set_in(input logic inf, input logic zero, input logic sgn,
                        input logic [N-1:0] k, input logic [N-1:0] m, input logic [N-1:0] e);
    in_is_inf = inf; in_is_zero = zero; in_sign = sgn; in_k = k; in_mant = m; cur_exp = e;
  endtask

  // Call at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic inf, input logic zero, input logic sgn,
                      input logic [N-1:0] k, input logic [N-1:0] m, input logic [N-1:0] e);
    int cyc;
    set_in(inf, zero, sgn, k, m, e);
    in_valid = 1'b1;
    cyc = 0;
    @(negedge clk);
    while (!in_ready && cyc < 50) begin @(negedge clk); cyc++; end
    if (!in_ready) check("send_timeout", 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int c;
    c = 0;
    while (sb.size() != 0 && c < 50) begin @(negedge clk); c++; end
    @(negedge clk);
    check(tag, 32'(sb.size()), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, n0;
    logic acc;
    logic [N-1:0] bp_k [4];
    logic [N-1:0] bp_m [4];
    logic [N-1:0] bp_e [4];
    bp_k = '{8'd0, 8'd1, 8'hF8, 8'd7};
    bp_m = '{8'h80, 8'hC0, 8'h80, 8'h80};
    bp_e = '{8'h40, 8'h68, 8'h01, 8'h7F};

    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_posit", 32'(out_posit), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid_rel", 32'(out_valid), 0);

    // Two-cycle latency on the first vector.
    send(0, 0, 0, 8'd0, 8'h80, 8'h40);
    @(negedge clk);
    check("lat_c1", 32'(out_valid), 0);
    @(negedge clk);
    check("lat_c2", 32'(out_valid), 1);
    check("lat_val", 32'(out_posit), 32'h40);
    @(posedge clk); #1;

    // Directed plan vectors, back-to-back.
    send(0, 0, 1, 8'd0,  8'h80, 8'hC0);
    send(0, 0, 0, 8'd1,  8'hC0, 8'h68);
    send(0, 0, 0, 8'd0,  8'h82, 8'h40);
    send(0, 0, 0, 8'd0,  8'h86, 8'h42);
    send(0, 0, 0, 8'd0,  8'h83, 8'h41);
    send(0, 0, 0, 8'd7,  8'h80, 8'h7F);
    send(0, 0, 0, 8'hF8, 8'h80, 8'h01);
    send(0, 0, 1, 8'hF8, 8'h80, 8'hFF);
    send(1, 0, 0, 8'd3,  8'hC0, 8'h80);
    send(0, 1, 1, 8'd3,  8'hC0, 8'h00);
    send(1, 1, 1, 8'd0,  8'h80, 8'h80);
    send(0, 0, 0, 8'd6,  8'h80, 8'h7F);
    send(0, 0, 0, 8'hFA, 8'h80, 8'h01);
    send(0, 0, 0, 8'hFB, 8'hC0, 8'h03);
    send(0, 0, 0, 8'd5,  8'hC0, 8'h7E);
    send(0, 0, 1, 8'd1,  8'hC0, 8'h98);
    drain("drain_directed");

    // Backpressure: stall output, then release.
    @(posedge clk); #1;
    idx = 0;
    n0 = n_out;
    for (int cyc = 0; cyc < 14; cyc++) begin
      out_ready = (cyc >= 6);
      if (idx < 4) begin
        set_in(0, 0, 0, bp_k[idx], bp_m[idx], bp_e[idx]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      if (cyc == 3) check("bp_hold_early", 32'(out_posit), 32'h40);
      if (cyc == 5) begin
        check("bp_accepted", 32'(idx), 2);
        check("bp_in_ready", 32'(in_ready), 0);
        check("bp_hold_valid", 32'(out_valid), 1);
        check("bp_hold", 32'(out_posit), 32'h40);
      end
      if (cyc >= 6 && cyc <= 9) check("bp_stream", 32'(out_valid), 1);
      @(posedge clk); #1;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    check("bp_count", 32'(n_out - n0), 4);
    check("bp_sb_empty", 32'(sb.size()), 0);

    // Reset with both stages full.
    out_ready = 1'b0;
    send(0, 0, 0, 8'd2, 8'h80, 8'h70);
    send(0, 0, 0, 8'd3, 8'h80, 8'h78);
    #1;
    rst = 1'b1;
    #1;
    check("rst_mid_valid", 32'(out_valid), 0);
    check("rst_mid_posit", 32'(out_posit), 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n0 = n_out;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_in_ready", 32'(in_ready), 1);
    send(0, 0, 0, 8'd1, 8'hC0, 8'h68);
    repeat (5) @(negedge clk);
    check("rst_mid_one_out", 32'(n_out - n0), 1);
    check("rst_mid_sb_empty", 32'(sb.size()), 0);

    // Random traffic against the reference model with random backpressure.
    @(posedge clk); #1;
    use_model = 1'b1;
    bp_rand = 1'b1;
    for (int i = 0; i < 150; i++) begin
      int r, kk;
      r = int'($urandom_range(0, 15));
      kk = int'($urandom_range(0, 20)) - 10;
      send(r == 0, r == 1, 1'($urandom), N'(kk), {1'b1, 7'($urandom)}, 8'h00);
    end
    bp_rand = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    drain("drain_random");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/posit_encode_round.md
Name: posit_encode_round

Overview:
- Pipelined encode stage directly downstream of the posit multiplier core.
- Consumes the unpacked result fields (special flags, sign, regime exponent k, exponent, normalised mantissa) and produces the packed N-bit posit.
- Applies round-to-nearest-even, saturation to maxpos/minpos, and two's-complement negation.
- Uses a two-stage valid/ready pipeline so it can sit between arithmetic and the register/write-back path.

Parameters:
- N, 8, posit width in bits (N >= 5).
- S, $clog2(N), width of internal regime-length fields.
- ES, 0, exponent field width; exp port is max(ES,1) bits wide and is ignored when ES=0.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream fields valid.
- in_ready  output  1  stage can accept fields this cycle.
- in_is_zero  input  1  result is zero.
- in_is_inf  input  1  result is NaR.
- in_sign  input  1  result sign (1 = negative).
- in_k  input  N  signed two's-complement regime value.
- in_exp  input  max(ES,1)  unsigned exponent.
- in_mant  input  N  normalised mantissa 1.f, hidden bit at bit N-1 (always 1 for finite non-zero).
- out_valid  output  1  out_posit valid.
- out_ready  input  1  downstream accepts out_posit.
- out_posit  output  N  packed posit.

Behaviour:
- Reset (async, active-high): s1_valid=0, s2_valid=0, out_valid=0, out_posit=0, in_ready=1 after reset release. Reset mid-operation discards all in-flight data; no output is produced for it.
- Handshake:
  - Transfer occurs when valid&&ready.
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv (combinational).
  - out_valid and out_posit are held stable while out_valid && !out_ready.
  - Latency is 2 cycles from accept to out_valid when unstalled; throughput is 1 per cycle. Order is preserved and there is no drop or duplication.
- Stage 1 (registered on accept):
  - Saturate k into the range kmin = -(N-2) .. kmax = N-2; record a sat_hi/sat_lo flag.
  - Build regime: k>=0 gives k+1 ones then a zero; k<0 gives -k zeros then a one.
  - Concatenate regime | exp (ES bits) | mant[N-2:0] (hidden bit dropped) into a left-aligned string of width at least 2N+ES.
  - Keep the top N-1 bits as the body.
  - guard = next bit; sticky = OR of all remaining bits.
  - Register the body, guard, sticky, sign, flags and saturation flags.
- Stage 2 (registered on advance):
  - Rounding: if guard && (sticky || body[0]), body = body+1.
  - sat_hi or post-round body of all ones gives maxpos 0 1..1. Rounding never carries into NaR.
  - sat_lo, or a body that would be all zeros for a finite non-zero input, gives minpos 0 0..01. A non-zero input never encodes to zero.
  - Packed value = {0, body}; if sign, out_posit = two's complement of the packed value.
- Special-case priority: in_is_inf gives 1 0..0 (NaR); else in_is_zero gives 0. Sign, k, exp and mant are ignored for special cases.
- Simultaneous accept and output in the same cycle is allowed with no bubble.

Test Plan:
- P8E0, k=0, mant=8'b1000_0000, sign=0 -> out_posit=8'h40 two cycles after accept; sign=1 -> 8'hC0.
- P8E0, k=1, mant=8'b1100_0000 -> 8'h68 (3.0).
- P8E0 rounding, k=0:
  - mant=8'b1000_0010 (tie, lsb 0) -> 8'h40.
  - mant=8'b1000_0110 (tie, lsb 1) -> 8'h42.
  - mant=8'b1000_0011 (above half) -> 8'h41.
- P8E0 saturation and specials:
  - k=7 -> 8'h7F; k=-8 -> 8'h01; k=-8 with sign=1 -> 8'hFF.
  - is_inf=1 -> 8'h80; is_zero=1 -> 8'h00.
  - is_inf=1 with is_zero=1 -> 8'h80.
- Backpressure:
  - out_ready=0 while driving in_valid=1 for 4 back-to-back inputs -> exactly 2 accepted, in_ready=0 afterwards, out_posit stable.
  - Raise out_ready -> all 4 results emerge in order, one per cycle, none lost or repeated.
- Reset mid-stream: assert rst with s1 and s2 both full -> out_valid=0 immediately (async); after release the next accepted input yields exactly one output 2 cycles later.
